// File: rtl/sync_burst_fifo_if.sv
// Write/read handshake bundle for sync_burst_fifo.
// The FIFO takes the slave side and the producer/consumer take the master side.
interface sync_burst_fifo_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int DEPTH_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   wr_en;
  logic                   wr_full;
  logic                   almost_full;
  logic [DEPTH_WIDTH:0]   water_level;
  logic                   rd_en;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   rd_empty;
  logic                   almost_empty;
  logic                   burst_rdy;
  logic                   err_clr;
  logic                   overflow;
  logic                   underflow;

  modport slave (
    input  wr_data, wr_en, rd_en, err_clr,
    output wr_full, almost_full, water_level, rd_data, rd_empty,
           almost_empty, burst_rdy, overflow, underflow
  );

  modport master (
    output wr_data, wr_en, rd_en, err_clr,
    input  wr_full, almost_full, water_level, rd_data, rd_empty,
           almost_empty, burst_rdy, overflow, underflow
  );
endinterface

// File: rtl/sync_burst_fifo.sv
// Single-clock FIFO with water level, burst-ready flag, sticky errors and optional FWFT read.
// The level counts every held word, including the FWFT output register.
module sync_burst_fifo #(
  parameter int DATA_WIDTH       = 256,
  parameter int DEPTH_WIDTH      = 8,
  parameter int ALMOST_FULL_NUM  = 241,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter int BURST_LEN        = 16,
  parameter int FWFT             = 0
) (
  input  logic               clk,
  input  logic               rst,
  sync_burst_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE   = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH:0]   LVL_ONE   = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH:0]   LVL_ZERO  = {(DEPTH_WIDTH+1){1'b0}};
  localparam logic [DEPTH_WIDTH:0]   LVL_DEPTH = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0]   LVL_AF    = ALMOST_FULL_NUM[DEPTH_WIDTH:0];
  localparam logic [DEPTH_WIDTH:0]   LVL_AE    = ALMOST_EMPTY_NUM[DEPTH_WIDTH:0];
  localparam logic [DEPTH_WIDTH:0]   LVL_BURST = BURST_LEN[DEPTH_WIDTH:0];

  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] r_wr_ptr;
  logic [DEPTH_WIDTH-1:0] r_rd_ptr;
  logic [DEPTH_WIDTH:0]   r_level;
  logic [DATA_WIDTH-1:0]  r_ram_q;
  logic [DATA_WIDTH-1:0]  r_rd_data;
  logic                   r_rd_pend;
  logic                   r_wr_full;
  logic                   r_almost_full;
  logic                   r_rd_empty;
  logic                   r_almost_empty;
  logic                   r_burst_rdy;
  logic                   r_overflow;
  logic                   r_underflow;

  logic                   w_wr_acc;
  logic                   w_rd_acc;
  logic                   w_ram_rd;
  logic                   w_out_valid_nxt;
  logic                   w_rd_empty_nxt;
  logic [DEPTH_WIDTH:0]   w_level_nxt;
  logic [DEPTH_WIDTH:0]   w_ram_cnt;

  // Accept decisions, next level and RAM read strobe
  always_comb begin
    w_wr_acc        = bus.wr_en & ~r_wr_full;
    w_rd_acc        = bus.rd_en & ~r_rd_empty;
    w_ram_cnt       = r_level;
    w_ram_rd        = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_rd_empty_nxt  = 1'b1;
    if (w_wr_acc && !w_rd_acc) begin
      w_level_nxt = r_level + LVL_ONE;
    end else if (!w_wr_acc && w_rd_acc) begin
      w_level_nxt = r_level - LVL_ONE;
    end else begin
      w_level_nxt = r_level;
    end
    // In FWFT the output register holds one word; only words already in RAM can refill it
    if (FWFT != 0) begin
      w_ram_cnt       = r_level - {{DEPTH_WIDTH{1'b0}}, ~r_rd_empty};
      w_ram_rd        = (r_rd_empty | w_rd_acc) & (w_ram_cnt != LVL_ZERO);
      w_out_valid_nxt = w_ram_rd | (~r_rd_empty & ~w_rd_acc);
      w_rd_empty_nxt  = ~w_out_valid_nxt;
    end else begin
      w_ram_rd        = w_rd_acc;
      w_rd_empty_nxt  = (w_level_nxt == LVL_ZERO);
    end
  end

  // Storage array: write port and synchronous read port, no reset
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
    if (w_ram_rd) begin
      r_ram_q <= r_mem[r_rd_ptr];
    end
  end

  // Pointers, level, flags, sticky errors and read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= {DEPTH_WIDTH{1'b0}};
      r_rd_ptr       <= {DEPTH_WIDTH{1'b0}};
      r_level        <= LVL_ZERO;
      r_rd_data      <= {DATA_WIDTH{1'b0}};
      r_rd_pend      <= 1'b0;
      r_wr_full      <= 1'b0;
      r_almost_full  <= 1'b0;
      r_rd_empty     <= 1'b1;
      r_almost_empty <= 1'b1;
      r_burst_rdy    <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_wr_ptr       <= w_wr_acc ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
      r_rd_ptr       <= w_ram_rd ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
      r_level        <= w_level_nxt;
      r_wr_full      <= (w_level_nxt == LVL_DEPTH);
      r_almost_full  <= (w_level_nxt >= LVL_AF);
      r_almost_empty <= (w_level_nxt <= LVL_AE);
      r_burst_rdy    <= (w_level_nxt >= LVL_BURST);
      r_rd_empty     <= w_rd_empty_nxt;
      r_overflow     <= (bus.wr_en & r_wr_full) | (r_overflow & ~bus.err_clr);
      r_underflow    <= (bus.rd_en & r_rd_empty) | (r_underflow & ~bus.err_clr);
      r_rd_pend      <= w_rd_acc;
      if (FWFT != 0) begin
        if (w_ram_rd) begin
          r_rd_data <= r_mem[r_rd_ptr];
        end
      end else if (r_rd_pend) begin
        r_rd_data <= r_ram_q;
      end
    end
  end

  assign bus.wr_full      = r_wr_full;
  assign bus.almost_full  = r_almost_full;
  assign bus.water_level  = r_level;
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_empty     = r_rd_empty;
  assign bus.almost_empty = r_almost_empty;
  assign bus.burst_rdy    = r_burst_rdy;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule
